mips8_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the 8-bit MIPS core. Sits directly upstream of the data unit.
- Decodes the 12-bit instruction word and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives the data unit's control inputs (opALU, selB, selAddrMI, selAw, selD, wR).
- Consumes the data unit's z/co/ov flags and a data-memory ready handshake.

---
 rtl/mips8_ctrl_pkg.sv | 64 ++++++
 rtl/mips8_ctrl_decode.sv | 39 +++
 rtl/mips8_ctrl_fsm.sv | 187 ++++++++++++++++++
 tb/tb_mips8_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips8_ctrl_pkg.sv
// mips8_ctrl_pkg -- shared definitions for the 8-bit MIPS multi-cycle control unit.
// Holds the FSM state encoding, opcode values, instruction classes, ALU operation
// codes and the selB / selAddrMI mux encodings used by the data unit.
package mips8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE   = 3'd0,
    C_IMM     = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_BRANCH  = 3'd4,
    C_JUMP    = 3'd5,
    C_HALT    = 3'd6,
    C_ILLEGAL = 3'd7
  } op_class_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_BCS  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_SLT = 5'd6;

  localparam logic [1:0] SELB_REG = 2'd0;
  localparam logic [1:0] SELB_IMM = 2'd1;
  localparam logic [1:0] SELB_ONE = 2'd2;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_HOLD   = 2'd3;

  // Arithmetic opcodes whose signed overflow can raise a trap.
  function automatic logic is_ov_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips8_ctrl_decode.sv
// mips8_ctrl_decode -- combinational opcode decoder.
// Ports:
//   opcode   in  4        instruction[11:8]
//   op_class out          instruction class driving the FSM
//   op_alu   out OPALU_W  ALU operation for this opcode (NOP for J/HALT/illegal)
module mips8_ctrl_decode
  import mips8_ctrl_pkg::*;
#(
  parameter int OPALU_W = 5
) (
  input  logic [3:0]         opcode,
  output op_class_e          op_class,
  output logic [OPALU_W-1:0] op_alu
);

  // Opcode to class and ALU operation; branches compare via SUB.
  always_comb begin
    op_class = C_ILLEGAL;
    op_alu   = OPALU_W'(ALU_NOP);
    case (opcode)
      OP_ADD:  begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_ADD); end
      OP_SUB:  begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_SUB); end
      OP_AND:  begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_AND); end
      OP_OR:   begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_OR);  end
      OP_XOR:  begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_XOR); end
      OP_SLT:  begin op_class = C_RTYPE;  op_alu = OPALU_W'(ALU_SLT); end
      OP_ADDI: begin op_class = C_IMM;    op_alu = OPALU_W'(ALU_ADD); end
      OP_LW:   begin op_class = C_LOAD;   op_alu = OPALU_W'(ALU_ADD); end
      OP_SW:   begin op_class = C_STORE;  op_alu = OPALU_W'(ALU_ADD); end
      OP_BEQ,
      OP_BNE,
      OP_BCS:  begin op_class = C_BRANCH; op_alu = OPALU_W'(ALU_SUB); end
      OP_J:    begin op_class = C_JUMP;   op_alu = OPALU_W'(ALU_NOP); end
      OP_HALT: begin op_class = C_HALT;   op_alu = OPALU_W'(ALU_NOP); end
      default: begin op_class = C_ILLEGAL; op_alu = OPALU_W'(ALU_NOP); end
    endcase
  end

endmodule

// File: rtl/mips8_ctrl_fsm.sv
// mips8_ctrl_fsm -- multi-cycle control unit for the 8-bit MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the data unit's controls.
// Optional feature macro CU_TRAP_EN: illegal opcodes and ADD/SUB/ADDI overflow
// enter the sticky TRAP state instead of being ignored.
// Ports:
//   clk, rst (sync, active high); instruction[11:0]; z/co/ov ALU flags; memReady
//   opALU, selB, selAddrMI, selAw, selD, wR   data unit controls
//   irLoad, memRd, memWr                       strobes
//   halted, memErr (sticky), stateDbg          status
module mips8_ctrl_fsm
  import mips8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPALU_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        instruction,
  input  logic               z,
  input  logic               co,
  input  logic               ov,
  input  logic               memReady,
  output logic [OPALU_W-1:0] opALU,
  output logic [1:0]         selB,
  output logic [1:0]         selAddrMI,
  output logic               selAw,
  output logic               selD,
  output logic               wR,
  output logic               irLoad,
  output logic               memRd,
  output logic               memWr,
  output logic               halted,
  output logic               memErr,
  output logic [2:0]         stateDbg
);

`ifdef CU_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;
  // Keeps every strobe low for the cycle(s) after a reset edge.
  logic               rst_hold_q, rst_hold_d;
  logic [8:0]         cnt_inc;
  logic [3:0]         opcode;
  op_class_e          op_class;
  logic [OPALU_W-1:0] op_alu;
  logic               ov_trap;
  logic               unused_bits;

  assign opcode      = instruction[11:8];
  assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
  assign ov_trap     = TRAP_EN & ov & is_ov_op(opcode);
  assign memErr      = mem_err_q;
  assign stateDbg    = state_q;
  assign unused_bits = ^{instruction[7:0], ov};

  mips8_ctrl_decode #(.OPALU_W(OPALU_W)) u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .op_alu   (op_alu)
  );

  // State, timeout counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      cnt_q      <= 8'd0;
      mem_err_q  <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_err_q  <= mem_err_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = 8'd0;
    mem_err_d  = mem_err_q;
    rst_hold_d = 1'b0;
    opALU      = OPALU_W'(ALU_NOP);
    selB       = SELB_REG;
    selAddrMI  = PC_HOLD;
    selAw      = 1'b0;
    selD       = 1'b0;
    wR         = 1'b0;
    irLoad     = 1'b0;
    memRd      = 1'b0;
    memWr      = 1'b0;
    halted     = (state_q == S_HALT) || (state_q == S_TRAP);
    if (rst_hold_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          irLoad  = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          case (op_class)
            C_JUMP: begin
              selAddrMI = PC_JUMP;
              state_d   = S_FETCH;
            end
            C_HALT: begin
              state_d = S_HALT;
            end
            C_ILLEGAL: begin
              // Without the trap feature an illegal opcode runs as a NOP.
              selAddrMI = TRAP_EN ? PC_HOLD : PC_INC;
              state_d   = TRAP_EN ? S_TRAP : S_EXEC;
            end
            default: begin
              selAddrMI = PC_INC;
              state_d   = S_EXEC;
            end
          endcase
        end
        S_EXEC: begin
          opALU = op_alu;
          case (op_class)
            C_RTYPE, C_IMM: begin
              selB    = (op_class == C_IMM) ? SELB_IMM : SELB_REG;
              state_d = ov_trap ? S_TRAP : S_WB;
            end
            C_LOAD, C_STORE: begin
              selB    = SELB_IMM;
              state_d = S_MEM;
            end
            C_BRANCH: begin
              selB = SELB_REG;
              if (opcode == OP_BCS) begin
                selAddrMI = co ? PC_BRANCH : PC_HOLD;
              end else begin
                selAddrMI = (z ^ (opcode == OP_BNE)) ? PC_BRANCH : PC_HOLD;
              end
              state_d = S_FETCH;
            end
            default: begin
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          opALU = op_alu;
          selB  = SELB_IMM;
          memRd = (op_class == C_LOAD);
          memWr = (op_class == C_STORE);
          // Completion has priority over the timeout on the same cycle.
          if (memReady) begin
            state_d = (op_class == C_LOAD) ? S_WB : S_FETCH;
          end else if (cnt_inc == TIMEOUT_LIM) begin
            mem_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
        S_WB: begin
          opALU   = op_alu;
          selB    = ((op_class == C_IMM) || (op_class == C_LOAD)) ? SELB_IMM : SELB_REG;
          wR      = 1'b1;
          selD    = (op_class == C_LOAD);
          selAw   = (op_class == C_RTYPE);
          state_d = S_FETCH;
        end
        S_HALT, S_TRAP: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips8_ctrl_fsm.sv
// Self-checking bench for mips8_ctrl_fsm: table of single-instruction vectors
// plus hand-written multi-cycle sequences (load wait, timeout, reset, halt, trap).
module tb_mips8_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [11:0] instruction;
  logic        z, co, ov, memReady;
  logic [4:0]  opALU;
  logic [1:0]  selB, selAddrMI;
  logic        selAw, selD, wR, irLoad, memRd, memWr, halted, memErr;
  logic [2:0]  stateDbg;

  int checks = 0;
  int errors = 0;

  mips8_ctrl_fsm #(.MEM_TIMEOUT(15), .OPALU_W(5)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .z(z), .co(co), .ov(ov),
    .memReady(memReady), .opALU(opALU), .selB(selB), .selAddrMI(selAddrMI),
    .selAw(selAw), .selD(selD), .wR(wR), .irLoad(irLoad), .memRd(memRd),
    .memWr(memWr), .halted(halted), .memErr(memErr), .stateDbg(stateDbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] instr;
    logic        z, co, ov;
    logic [1:0]  dec_pc;
    logic [2:0]  dec_next;
    logic [4:0]  exe_alu;
    logic [1:0]  exe_selb;
    logic [1:0]  exe_pc;
    logic [2:0]  exe_next;
    logic        wb_selaw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [11:0] i, input logic zz, input logic cc, input logic oo,
                              input logic [1:0] dpc, input logic [2:0] dn, input logic [4:0] alu,
                              input logic [1:0] sb, input logic [1:0] epc, input logic [2:0] en,
                              input logic aw);
    vec_t v;
    v.instr = i; v.z = zz; v.co = cc; v.ov = oo; v.dec_pc = dpc; v.dec_next = dn;
    v.exe_alu = alu; v.exe_selb = sb; v.exe_pc = epc; v.exe_next = en; v.wb_selaw = aw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH, run instr through DECODE and EXEC into MEM.
  task automatic run_to_mem(input logic [11:0] instr);
    instruction = instr;
    memReady = 1'b0;
    tick();
    tick();
    chk("exec state", 32'(stateDbg), 32'd2);
    chk("exec no mem strobe", 32'({memRd, memWr}), 32'd0);
    tick();
    chk("mem entry state", 32'(stateDbg), 32'd3);
  endtask

  task automatic short_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int rd_cycles;
    rst = 1'b1; instruction = 12'h000; z = 1'b0; co = 1'b0; ov = 1'b0; memReady = 1'b0;

    //      instr    z     co    ov    dpc   dnext alu   selb  epc   enext selaw
    tbl.push_back(mk(12'h123, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd3, 3'd4, 1'b1)); // SUB
    tbl.push_back(mk(12'h045, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd1, 2'd0, 2'd3, 3'd4, 1'b1)); // ADD
    tbl.push_back(mk(12'h2AB, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd3, 2'd0, 2'd3, 3'd4, 1'b1)); // AND
    tbl.push_back(mk(12'h3CD, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd4, 2'd0, 2'd3, 3'd4, 1'b1)); // OR
    tbl.push_back(mk(12'h4EF, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd5, 2'd0, 2'd3, 3'd4, 1'b1)); // XOR
    tbl.push_back(mk(12'h57F, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd1, 2'd1, 2'd3, 3'd4, 1'b0)); // ADDI
    tbl.push_back(mk(12'hC12, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd6, 2'd0, 2'd3, 3'd4, 1'b1)); // SLT
    tbl.push_back(mk(12'h805, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd1, 3'd0, 1'b0)); // BEQ taken
    tbl.push_back(mk(12'h805, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd3, 3'd0, 1'b0)); // BEQ not
    tbl.push_back(mk(12'h906, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd3, 3'd0, 1'b0)); // BNE not
    tbl.push_back(mk(12'h906, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd1, 3'd0, 1'b0)); // BNE taken
    tbl.push_back(mk(12'hB07, 1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd1, 3'd0, 1'b0)); // BCS taken
    tbl.push_back(mk(12'hB07, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 5'd2, 2'd0, 2'd3, 3'd0, 1'b0)); // BCS not
    tbl.push_back(mk(12'hA40, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 5'd0, 2'd0, 2'd3, 3'd0, 1'b0)); // J
`ifndef CU_TRAP_EN
    tbl.push_back(mk(12'hD00, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd0, 2'd0, 2'd3, 3'd0, 1'b0)); // illegal D
    tbl.push_back(mk(12'hE11, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 5'd0, 2'd0, 2'd3, 3'd0, 1'b0)); // illegal E
    tbl.push_back(mk(12'h012, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 5'd1, 2'd0, 2'd3, 3'd4, 1'b1)); // ADD ov ignored
`endif

    // Reset held two cycles.
    tick();
    tick();
    chk("reset stateDbg", 32'(stateDbg), 32'd0);
    chk("reset wR", 32'(wR), 32'd0);
    chk("reset selAddrMI", 32'(selAddrMI), 32'd3);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset memErr", 32'(memErr), 32'd0);
    chk("reset irLoad low", 32'(irLoad), 32'd0);
    rst = 1'b0;
    tick();
    chk("post-reset irLoad", 32'(irLoad), 32'd1);

    // Table-driven single instructions, each starting in FETCH.
    for (int i = 0; i < tbl.size(); i++) begin
      instruction = tbl[i].instr; z = tbl[i].z; co = tbl[i].co; ov = tbl[i].ov; memReady = 1'b0;
      #1;
      chk($sformatf("v%0d fetch state", i), 32'(stateDbg), 32'd0);
      chk($sformatf("v%0d fetch irLoad", i), 32'(irLoad), 32'd1);
      tick();
      chk($sformatf("v%0d decode state", i), 32'(stateDbg), 32'd1);
      chk($sformatf("v%0d decode selAddrMI", i), 32'(selAddrMI), 32'(tbl[i].dec_pc));
      tick();
      chk($sformatf("v%0d after decode", i), 32'(stateDbg), 32'(tbl[i].dec_next));
      if (tbl[i].dec_next == 3'd2) begin
        chk($sformatf("v%0d exec opALU", i), 32'(opALU), 32'(tbl[i].exe_alu));
        chk($sformatf("v%0d exec selB", i), 32'(selB), 32'(tbl[i].exe_selb));
        chk($sformatf("v%0d exec selAddrMI", i), 32'(selAddrMI), 32'(tbl[i].exe_pc));
        chk($sformatf("v%0d exec wR", i), 32'(wR), 32'd0);
        tick();
        chk($sformatf("v%0d after exec", i), 32'(stateDbg), 32'(tbl[i].exe_next));
        if (tbl[i].exe_next == 3'd4) begin
          chk($sformatf("v%0d wb wR", i), 32'(wR), 32'd1);
          chk($sformatf("v%0d wb selAw", i), 32'(selAw), 32'(tbl[i].wb_selaw));
          chk($sformatf("v%0d wb selD", i), 32'(selD), 32'd0);
          chk($sformatf("v%0d wb opALU", i), 32'(opALU), 32'(tbl[i].exe_alu));
          chk($sformatf("v%0d wb selAddrMI", i), 32'(selAddrMI), 32'd3);
          tick();
        end
      end
    end
    z = 1'b0; co = 1'b0; ov = 1'b0;
    #1;
    chk("table end state", 32'(stateDbg), 32'd0);

    // LW with memReady after three wait cycles.
    run_to_mem(12'h610);
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      memReady = (i == 3);
      #1;
      chk("lw mem state", 32'(stateDbg), 32'd3);
      chk("lw mem opALU/selB", 32'({opALU, selB}), 32'({5'd1, 2'd1}));
      rd_cycles += int'(memRd);
      tick();
    end
    memReady = 1'b0;
    #1;
    chk("lw memRd cycles", 32'(rd_cycles), 32'd4);
    chk("lw wb state", 32'(stateDbg), 32'd4);
    chk("lw wb memRd", 32'(memRd), 32'd0);
    chk("lw wb wR", 32'(wR), 32'd1);
    chk("lw wb selD", 32'(selD), 32'd1);
    chk("lw wb selAw", 32'(selAw), 32'd0);
    tick();
    chk("lw end state", 32'(stateDbg), 32'd0);

    // SW with memReady only on the timeout cycle: completion wins.
    run_to_mem(12'h730);
    for (int i = 0; i < 15; i++) begin
      memReady = (i == 14);
      #1;
      chk("sw late mem state", 32'(stateDbg), 32'd3);
      tick();
    end
    memReady = 1'b0;
    #1;
    chk("sw late state", 32'(stateDbg), 32'd0);
    chk("sw late memErr", 32'(memErr), 32'd0);
    chk("sw late halted", 32'(halted), 32'd0);

    // SW timeout with memReady never asserted.
    run_to_mem(12'h720);
    for (int i = 0; i < 15; i++) begin
      chk("sw to mem state", 32'(stateDbg), 32'd3);
      chk("sw to memWr", 32'(memWr), 32'd1);
      chk("sw to halted", 32'(halted), 32'd0);
      tick();
    end
    chk("timeout state", 32'(stateDbg), 32'd5);
    chk("timeout halted", 32'(halted), 32'd1);
    chk("timeout memErr", 32'(memErr), 32'd1);
    chk("timeout memWr", 32'(memWr), 32'd0);
    tick();
    tick();
    chk("timeout sticky state", 32'(stateDbg), 32'd5);
    chk("timeout sticky memErr", 32'(memErr), 32'd1);
    rst = 1'b1;
    tick();
    chk("timeout rst memErr", 32'(memErr), 32'd0);
    chk("timeout rst halted", 32'(halted), 32'd0);
    chk("timeout rst state", 32'(stateDbg), 32'd0);
    rst = 1'b0;
    tick();
    chk("timeout rst irLoad", 32'(irLoad), 32'd1);

    // Reset landing mid-MEM.
    run_to_mem(12'h740);
    tick();
    tick();
    chk("midmem memWr before", 32'(memWr), 32'd1);
    rst = 1'b1;
    tick();
    chk("midmem memWr", 32'(memWr), 32'd0);
    chk("midmem memErr", 32'(memErr), 32'd0);
    chk("midmem state", 32'(stateDbg), 32'd0);
    chk("midmem irLoad", 32'(irLoad), 32'd0);
    rst = 1'b0;
    tick();
    chk("midmem release irLoad", 32'(irLoad), 32'd1);

    // HALT instruction.
    instruction = 12'hF00;
    tick();
    chk("halt decode selAddrMI", 32'(selAddrMI), 32'd3);
    tick();
    chk("halt state", 32'(stateDbg), 32'd5);
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt strobes", 32'({wR, irLoad, memRd, memWr}), 32'd0);
    tick();
    tick();
    chk("halt sticky", 32'(stateDbg), 32'd5);
    short_reset();
    chk("halt rst state", 32'(stateDbg), 32'd0);

`ifdef CU_TRAP_EN
    // Illegal opcode traps from DECODE.
    instruction = 12'hD00;
    tick();
    tick();
    chk("trap illegal state", 32'(stateDbg), 32'd6);
    chk("trap illegal halted", 32'(halted), 32'd1);
    tick();
    chk("trap illegal sticky", 32'(stateDbg), 32'd6);
    short_reset();
    // ADD overflow traps from EXEC without any register write.
    instruction = 12'h012; ov = 1'b1;
    tick();
    tick();
    chk("trap ov exec wR", 32'(wR), 32'd0);
    tick();
    chk("trap ov state", 32'(stateDbg), 32'd6);
    chk("trap ov halted", 32'(halted), 32'd1);
    chk("trap ov wR", 32'(wR), 32'd0);
    tick();
    chk("trap ov wR later", 32'(wR), 32'd0);
    ov = 1'b0;
    short_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
